// File: rtl/parity_frame_gen_if.sv
// Word-in / symbol-out bundle between an upstream word source, the frame
// generator and the downstream 3-bit parity checker.
interface parity_frame_gen_if #(
    parameter int WORD_W = 8
) ();

    logic [WORD_W-1:0] in_data;
    logic              in_mode;
    logic              in_err;
    logic              in_valid;
    logic              in_ready;

    logic [2:0]        out_data;
    logic              out_mode;
    logic              out_valid;
    logic              out_last;

    // The word source (or a bench) owns the request side and watches the symbols.
    modport master (
        output in_data,
        output in_mode,
        output in_err,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_mode,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  in_data,
        input  in_mode,
        input  in_err,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_mode,
        output out_valid,
        output out_last
    );

endinterface

// File: rtl/parity_frame_gen.sv
// Slices accepted words into 2-bit chunks (MSB first) and emits one
// {parity, chunk} symbol per clock, with optional parity corruption and idle gaps.
module parity_frame_gen #(
    parameter int WORD_W = 8,
    parameter int GAP    = 0
) (
    input  logic                clk,
    input  logic                rst,
    parity_frame_gen_if.slave   bus,
    output logic [7:0]          word_cnt
);

    localparam int NSYM  = WORD_W / 2;
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);
    localparam logic [3:0]       GAP_LOAD = 4'(GAP);

    generate
        if ((WORD_W % 2) != 0 || WORD_W < 2) begin : gBadWidth
            $error("parity_frame_gen: WORD_W must be even and >= 2");
        end
        if (GAP < 0 || GAP > 15) begin : gBadGap
            $error("parity_frame_gen: GAP must be within 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    state_e            state_q,    state_d;
    logic [IDX_W-1:0]  symIdx_q,   symIdx_d;
    logic [3:0]        gapCnt_q,   gapCnt_d;
    logic [WORD_W-1:0] word_q,     word_d;
    logic              mode_q,     mode_d;
    logic              err_q,      err_d;
    logic [2:0]        outData_q,  outData_d;
    logic              outMode_q,  outMode_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q,  outLast_d;
    logic [7:0]        wordCnt_q,  wordCnt_d;

    logic              inReady;
    logic              accept;
    logic [IDX_W-1:0]  nextIdx;

    // Symbol k is the k-th 2-bit chunk from the top; the err flag only ever hits symbol 0.
    function automatic logic [2:0] makeSym(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  k,
        input logic              mode,
        input logic              err
    );
        logic [WORD_W-1:0] shifted;
        logic [1:0]        chunk;
        logic              par;
        shifted = word << {k, 1'b0};
        chunk   = shifted[WORD_W-1 -: 2];
        par     = (^chunk) ^ mode ^ (err && (k == '0));
        return {par, chunk};
    endfunction

    // Ready is purely a function of state, so it reads 1 in IDLE even while held in reset.
    assign inReady = (state_q == ST_IDLE) ||
                     ((GAP == 0) && (state_q == ST_SEND) && (symIdx_q == LAST_IDX));
    assign accept  = bus.in_valid && inReady;
    assign nextIdx = symIdx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        symIdx_d   = symIdx_q;
        gapCnt_d   = gapCnt_q;
        word_d     = word_q;
        mode_d     = mode_q;
        err_d      = err_q;
        outData_d  = outData_q;
        outMode_d  = outMode_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        wordCnt_d  = wordCnt_q;

        case (state_q)
            ST_IDLE: begin
                outValid_d = 1'b0;
                outLast_d  = 1'b0;
            end
            ST_SEND: begin
                if (symIdx_q == LAST_IDX) begin
                    wordCnt_d  = wordCnt_q + 8'd1;
                    symIdx_d   = '0;
                    outValid_d = 1'b0;
                    outLast_d  = 1'b0;
                    if (GAP > 0) begin
                        state_d  = ST_GAP;
                        gapCnt_d = GAP_LOAD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    symIdx_d  = nextIdx;
                    outData_d = makeSym(word_q, nextIdx, mode_q, err_q);
                    outLast_d = (nextIdx == LAST_IDX);
                end
            end
            ST_GAP: begin
                gapCnt_d = gapCnt_q - 4'd1;
                if (gapCnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new word overrides the idle/end-of-word decision, which gives back-to-back framing.
        if (accept) begin
            state_d    = ST_SEND;
            symIdx_d   = '0;
            word_d     = bus.in_data;
            mode_d     = bus.in_mode;
            err_d      = bus.in_err;
            outData_d  = makeSym(bus.in_data, '0, bus.in_mode, bus.in_err);
            outMode_d  = bus.in_mode;
            outValid_d = 1'b1;
            outLast_d  = (LAST_IDX == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            symIdx_q   <= '0;
            gapCnt_q   <= '0;
            word_q     <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            outData_q  <= '0;
            outMode_q  <= 1'b0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            wordCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            symIdx_q   <= symIdx_d;
            gapCnt_q   <= gapCnt_d;
            word_q     <= word_d;
            mode_q     <= mode_d;
            err_q      <= err_d;
            outData_q  <= outData_d;
            outMode_q  <= outMode_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            wordCnt_q  <= wordCnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_data  = outData_q;
    assign bus.out_mode  = outMode_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
    assign word_cnt      = wordCnt_q;

endmodule

// File: tb/tb_parity_frame_gen.sv
// Bench for parity_frame_gen: a queue-of-symbols reference model for the GAP=0
// instance, plus a GAP=3 instance checked around its idle gaps.
module tb_parity_frame_gen;

    localparam int WORD_W = 8;
    localparam int NSYM   = WORD_W / 2;
    localparam int GAPN   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    parity_frame_gen_if #(.WORD_W(WORD_W)) bus ();
    parity_frame_gen_if #(.WORD_W(WORD_W)) gapBus ();
    logic [7:0] wordCnt;
    logic [7:0] gapWordCnt;

    parity_frame_gen #(.WORD_W(WORD_W), .GAP(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .word_cnt (wordCnt)
    );

    parity_frame_gen #(.WORD_W(WORD_W), .GAP(GAPN)) dutGap (
        .clk      (clk),
        .rst      (rst),
        .bus      (gapBus),
        .word_cnt (gapWordCnt)
    );

    typedef struct packed {
        logic [2:0] data;
        logic       mode;
        logic       last;
    } sym_t;

    // Front of the queue is the symbol on the wire; empty means nothing valid.
    sym_t       symQ[$];
    logic [7:0] modelCnt;
    logic [2:0] heldData;
    logic       heldMode;
    int         vecCount  = 0;
    int         missCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit modelReady();
        return symQ.size() <= 1;
    endfunction

    task automatic modelReset();
        symQ.delete();
        modelCnt = 8'd0;
        heldData = 3'd0;
        heldMode = 1'b0;
    endtask

    // One clock edge: the displayed symbol leaves, and an accepted word adds its NSYM symbols.
    task automatic modelEdge(input logic acc, input logic [WORD_W-1:0] d, input logic m, input logic e);
        sym_t s;
        if (symQ.size() > 0) begin
            s = symQ.pop_front();
            if (s.last) modelCnt = modelCnt + 8'd1;
        end
        if (acc) begin
            for (int k = 0; k < NSYM; k++) begin
                int   ch;
                logic p;
                ch = (int'(d) >> (WORD_W - 2 - 2 * k)) % 4;
                p  = ((ch % 2) != (ch / 2)) ^ m ^ (e && (k == 0));
                s.data = {p, 2'(ch)};
                s.mode = m;
                s.last = (k == NSYM - 1);
                symQ.push_back(s);
            end
        end
        if (symQ.size() > 0) begin
            heldData = symQ[0].data;
            heldMode = symQ[0].mode;
        end
    endtask

    task automatic checkAll();
        checkOutput("in_ready", bus.in_ready, modelReady());
        checkOutput("word_cnt", wordCnt, modelCnt);
        if (symQ.size() > 0) begin
            checkOutput("out_valid", bus.out_valid, 1);
            checkOutput("out_data", bus.out_data, symQ[0].data);
            checkOutput("out_mode", bus.out_mode, symQ[0].mode);
            checkOutput("out_last", bus.out_last, symQ[0].last);
        end else begin
            checkOutput("out_valid", bus.out_valid, 0);
            checkOutput("out_data_hold", bus.out_data, heldData);
            checkOutput("out_mode_hold", bus.out_mode, heldMode);
            checkOutput("out_last", bus.out_last, 0);
        end
    endtask

    // Check the current cycle at negedge, drive the next inputs, then step the model on the edge.
    task automatic applyStimulus(input logic v, input logic [WORD_W-1:0] d, input logic m, input logic e);
        logic acc;
        @(negedge clk);
        checkAll();
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_mode  = m;
        bus.in_err   = e;
        acc = v && modelReady();
        @(posedge clk);
        modelEdge(acc, d, m, e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    logic [2:0] katMode0 [4] = '{3'b110, 3'b011, 3'b101, 3'b000};
    logic [2:0] katMode1 [4] = '{3'b010, 3'b111, 3'b001, 3'b100};
    logic [2:0] katErr   [4] = '{3'b010, 3'b011, 3'b101, 3'b000};

    initial begin
        int waited;

        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_mode     = 1'b0;
        bus.in_err      = 1'b0;
        gapBus.in_valid = 1'b1;
        gapBus.in_data  = 8'hA5;
        gapBus.in_mode  = 1'b0;
        gapBus.in_err   = 1'b0;
        modelReset();

        #12;
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_mode", bus.out_mode, 0);
        checkOutput("rst_out_last", bus.out_last, 0);
        checkOutput("rst_word_cnt", wordCnt, 0);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // Known-answer words for 0xB4: even, odd and corrupted first symbol.
        applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0);
        for (int i = 0; i < NSYM; i++) begin
            #1 checkOutput("kat_even", bus.out_data, katMode0[i]);
            checkOutput("kat_even_last", bus.out_last, (i == NSYM - 1));
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
        idleCycles(1);
        applyStimulus(1'b1, 8'hB4, 1'b1, 1'b0);
        for (int i = 0; i < NSYM; i++) begin
            #1 checkOutput("kat_odd", bus.out_data, katMode1[i]);
            checkOutput("kat_odd_xor", ^bus.out_data, 1);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
        idleCycles(1);
        applyStimulus(1'b1, 8'hB4, 1'b0, 1'b1);
        for (int i = 0; i < NSYM; i++) begin
            #1 checkOutput("kat_err", bus.out_data, katErr[i]);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
        idleCycles(2);

        // Back-to-back 0x00 then 0xFF with valid held; the second word is taken on the last symbol.
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < NSYM; i++) applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        idleCycles(NSYM + 2);

        // The GAP instance must sit GAPN cycles with valid and ready low after each last symbol.
        for (int rep = 0; rep < 2; rep++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (gapBus.out_last !== 1'b1 && waited < 40);
            checkOutput("gap_wait_last", gapBus.out_last, 1);
            for (int i = 0; i < GAPN; i++) begin
                @(negedge clk);
                checkOutput("gap_out_valid", gapBus.out_valid, 0);
                checkOutput("gap_in_ready", gapBus.in_ready, 0);
            end
            @(negedge clk);
            checkOutput("gap_idle_ready", gapBus.in_ready, 1);
            checkOutput("gap_idle_valid", gapBus.out_valid, 0);
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end
        idleCycles(NSYM + 2);

        // Asynchronous reset in the middle of the second symbol throws the word away.
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_out_valid", bus.out_valid, 0);
        checkOutput("arst_out_data", bus.out_data, 0);
        checkOutput("arst_out_mode", bus.out_mode, 0);
        checkOutput("arst_out_last", bus.out_last, 0);
        checkOutput("arst_word_cnt", wordCnt, 0);
        checkOutput("arst_in_ready", bus.in_ready, 1);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h96, 1'b0, 1'b0);
        #1 checkOutput("arst_restart_sym0", bus.out_data, 3'b110);
        idleCycles(NSYM + 1);

        // 256 back-to-back words take the counter all the way round.
        for (int i = 0; i < 256 * NSYM; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        idleCycles(NSYM + 2);
        checkOutput("wrap_word_cnt", wordCnt, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
